// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a one-entry skid buffer, flush support and a
// saturating count of valid entries discarded by flush.
module if_id_skid_stage #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
    parameter int                CNT_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [INST_W-1:0] out_inst_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    logic [1:0]        occ_reg, occ_next;
    logic [PC_W-1:0]   main_pc_reg, main_pc_next;
    logic [INST_W-1:0] main_inst_reg, main_inst_next;
    logic [PC_W-1:0]   skid_pc_reg, skid_pc_next;
    logic [INST_W-1:0] skid_inst_reg, skid_inst_next;
    logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;
    logic [CNT_W:0]    drop_sum;
    logic              accept;
    logic              transfer;

    // Ready depends only on registered occupancy, never on the consumer.
    assign in_ready_o  = (occ_reg != 2'd2) && !rst_i;
    assign out_valid_o = (occ_reg != 2'd0) && !rst_i;
    assign out_pc_o    = out_valid_o ? main_pc_reg : '0;
    assign out_inst_o  = out_valid_o ? main_inst_reg : NOP_INST;
    assign occ_o       = occ_reg;
    assign drop_cnt_o  = drop_cnt_reg;

    assign accept   = in_valid_i && in_ready_o && !flush_i;
    assign transfer = out_valid_o && out_ready_i;

    // One extra bit catches overflow so the counter can clamp instead of wrap.
    assign drop_sum = {1'b0, drop_cnt_reg} + (CNT_W + 1)'(occ_reg);

    always_comb begin
        occ_next       = occ_reg;
        main_pc_next   = main_pc_reg;
        main_inst_next = main_inst_reg;
        skid_pc_next   = skid_pc_reg;
        skid_inst_next = skid_inst_reg;
        drop_cnt_next  = drop_cnt_reg;

        if (flush_i) begin
            occ_next       = 2'd0;
            main_pc_next   = '0;
            main_inst_next = NOP_INST;
            skid_pc_next   = '0;
            skid_inst_next = NOP_INST;
            drop_cnt_next  = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end else begin
            case (occ_reg)
                2'd0: begin
                    if (accept) begin
                        main_pc_next   = pc_i;
                        main_inst_next = inst_i;
                        occ_next       = 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && transfer) begin
                        main_pc_next   = pc_i;
                        main_inst_next = inst_i;
                    end else if (transfer) begin
                        occ_next = 2'd0;
                    end else if (accept) begin
                        skid_pc_next   = pc_i;
                        skid_inst_next = inst_i;
                        occ_next       = 2'd2;
                    end
                end
                2'd2: begin
                    if (transfer) begin
                        main_pc_next   = skid_pc_reg;
                        main_inst_next = skid_inst_reg;
                        occ_next       = 2'd1;
                    end
                end
                default: occ_next = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_reg       <= 2'd0;
            main_pc_reg   <= '0;
            main_inst_reg <= NOP_INST;
            skid_pc_reg   <= '0;
            skid_inst_reg <= NOP_INST;
            drop_cnt_reg  <= '0;
        end else begin
            occ_reg       <= occ_next;
            main_pc_reg   <= main_pc_next;
            main_inst_reg <= main_inst_next;
            skid_pc_reg   <= skid_pc_next;
            skid_inst_reg <= skid_inst_next;
            drop_cnt_reg  <= drop_cnt_next;
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: a FIFO-queue model checked every cycle
// plus literal expectations at key points.
module tb_if_id_skid_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] pc_i = '0;
    logic [31:0] inst_i = '0;
    logic        flush_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_pc_o;
    logic [31:0] out_inst_o;
    logic [1:0]  occ_o;
    logic [1:0]  drop_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    if_id_skid_stage #(.PC_W(32), .INST_W(32), .NOP_INST(NOP), .CNT_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
        .occ_o(occ_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: the stage is a FIFO of depth 2 with flush, reset and a clamped drop count.
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    int          m_drop = 0;
    bit          m_live = 0;

    always @(posedge clk_i) begin
        bit acc;
        bit xfer;
        acc  = in_valid_i && !rst_i && !flush_i && (q_pc.size() < 2);
        xfer = out_ready_i && !rst_i && (q_pc.size() > 0);
        if (rst_i) begin
            q_pc.delete(); q_inst.delete(); m_drop = 0; m_live = 1;
        end else if (flush_i) begin
            m_drop = m_drop + q_pc.size();
            if (m_drop > 3) m_drop = 3;
            q_pc.delete(); q_inst.delete();
        end else begin
            if (xfer) begin
                void'(q_pc.pop_front()); void'(q_inst.pop_front());
            end
            if (acc) begin
                q_pc.push_back(pc_i); q_inst.push_back(inst_i);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (m_live) begin
            logic        ev;
            logic [31:0] epc;
            logic [31:0] einst;
            ev    = (q_pc.size() != 0) && !rst_i;
            epc   = ev ? q_pc[0] : 32'h0;
            einst = ev ? q_inst[0] : NOP;
            chk("m_out_valid", {31'b0, out_valid_o}, {31'b0, ev});
            chk("m_out_pc", out_pc_o, epc);
            chk("m_out_inst", out_inst_o, einst);
            chk("m_occ", {30'b0, occ_o}, q_pc.size());
            chk("m_in_ready", {31'b0, in_ready_o}, {31'b0, (q_pc.size() != 2) && !rst_i});
            chk("m_drop", {30'b0, drop_cnt_o}, m_drop);
        end
    end

    // Apply inputs for one cycle; returns 1 time unit after the edge.
    task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                         input logic f, input logic o);
        rst_i = r; in_valid_i = v; pc_i = pc; inst_i = pc ^ 32'hA5A5_0000;
        flush_i = f; out_ready_i = o;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("rst_occ", {30'b0, occ_o}, 0);
        chk("rst_valid", {31'b0, out_valid_o}, 0);
        chk("rst_ready", {31'b0, in_ready_o}, 0);
        chk("rst_inst", out_inst_o, NOP);
        chk("rst_drop", {30'b0, drop_cnt_o}, 0);
        drive(0, 0, 0, 0, 1);
        chk("rel_ready", {31'b0, in_ready_o}, 1);

        // Streaming at full rate
        drive(0, 1, 32'h100, 0, 1);
        chk("s_pc0", out_pc_o, 32'h100);
        chk("s_inst0", out_inst_o, 32'hA5A5_0100);
        drive(0, 1, 32'h104, 0, 1);
        chk("s_pc1", out_pc_o, 32'h104);
        chk("s_occ1", {30'b0, occ_o}, 1);
        drive(0, 1, 32'h108, 0, 1);
        chk("s_pc2", out_pc_o, 32'h108);
        chk("s_occ2", {30'b0, occ_o}, 1);
        drive(0, 0, 0, 0, 1);
        chk("s_drain", {30'b0, occ_o}, 0);

        // Stall into skid, then release
        drive(0, 1, 32'h200, 0, 0);
        drive(0, 1, 32'h204, 0, 0);
        chk("st_occ2", {30'b0, occ_o}, 2);
        chk("st_ready", {31'b0, in_ready_o}, 0);
        drive(0, 1, 32'h208, 0, 0);
        chk("st_hold", out_pc_o, 32'h200);
        drive(0, 1, 32'h208, 0, 1);
        chk("st_rel1", out_pc_o, 32'h204);
        drive(0, 1, 32'h208, 0, 1);
        chk("st_rel2", out_pc_o, 32'h208);
        drive(0, 0, 0, 0, 1);
        chk("st_empty", {30'b0, occ_o}, 0);

        // Flush at occ 2 with incoming entry
        drive(0, 1, 32'h300, 0, 0);
        drive(0, 1, 32'h304, 0, 0);
        drive(0, 1, 32'h308, 1, 1);
        chk("f_occ", {30'b0, occ_o}, 0);
        chk("f_valid", {31'b0, out_valid_o}, 0);
        chk("f_inst", out_inst_o, NOP);
        chk("f_drop", {30'b0, drop_cnt_o}, 2);
        drive(0, 0, 0, 0, 1);
        chk("f_absent", {30'b0, occ_o}, 0);

        // Saturation: three more flushes at occ 2
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 32'h310 + k * 8, 0, 0);
            drive(0, 1, 32'h314 + k * 8, 0, 0);
            drive(0, 0, 0, 1, 0);
            chk("sat_drop", {30'b0, drop_cnt_o}, 3);
        end

        // Reset beats flush with occ 2
        drive(0, 1, 32'h400, 0, 0);
        drive(0, 1, 32'h404, 0, 0);
        drive(1, 1, 32'h408, 1, 1);
        chk("rf_occ", {30'b0, occ_o}, 0);
        chk("rf_drop", {30'b0, drop_cnt_o}, 0);
        chk("rf_ready", {31'b0, in_ready_o}, 0);
        drive(0, 0, 0, 0, 0);
        chk("rf_ready_after", {31'b0, in_ready_o}, 1);

        // Flush at occ 1 counts one
        drive(0, 1, 32'h500, 0, 0);
        drive(0, 0, 0, 1, 0);
        chk("f1_drop", {30'b0, drop_cnt_o}, 1);

        // Mixed traffic checked by the model
        for (int i = 0; i < 40; i++)
            drive(0, (i % 3) != 0, 32'h600 + i * 4, i == 25, (i % 4) != 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("end_empty", {30'b0, occ_o}, 0);

        @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_skid_stage.md
IF_ID_SKID_STAGE -- requirements
Module: if_id_skid_stage

Interface
REQ-001 Parameter PC_W, default 32, width of program-counter field.
REQ-002 Parameter INST_W, default 32, width of instruction field.
REQ-003 Parameter NOP_INST, default 32'h0000_0013, instruction driven on out_inst_o when no valid entry is presented.
REQ-004 Parameter CNT_W, default 8, width of flush-drop counter.
REQ-005 Port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 Port rst_i  input  1  reset, synchronous, active-high.
REQ-007 Port in_valid_i  input  1  IF offers pc_i/inst_i this cycle.
REQ-008 Port in_ready_o  output  1  stage can accept an entry this cycle.
REQ-009 Port pc_i  input  PC_W  fetched PC.
REQ-010 Port inst_i  input  INST_W  fetched instruction.
REQ-011 Port flush_i  input  1  discard all held and incoming entries (branch taken).
REQ-012 Port out_valid_o  output  1  out_pc_o/out_inst_o hold a valid entry.
REQ-013 Port out_ready_i  input  1  ID consumes the presented entry (deasserted on hazard stall).
REQ-014 Port out_pc_o  output  PC_W  presented PC.
REQ-015 Port out_inst_o  output  INST_W  presented instruction.
REQ-016 Port occ_o  output  2  entries held (0, 1, 2).
REQ-017 Port drop_cnt_o  output  CNT_W  saturating count of valid entries discarded by flush.

Function
REQ-018 Storage: main register (presented to output) and skid register; occupancy occ in {0,1,2}; skid used only when occ=2.
REQ-019 in_ready_o = (occ != 2) and !rst_i, combinational from registered occ; no dependency on out_ready_i.
REQ-020 Accept = in_valid_i & in_ready_o & !flush_i; transfer = out_valid_o & out_ready_i.
REQ-021 out_valid_o = (occ != 0); when occ=0 out_pc_o = 0 and out_inst_o = NOP_INST.
REQ-022 occ=0: accept -> main loaded, occ 1; else unchanged.
REQ-023 occ=1: accept & transfer -> main reloaded, occ 1; transfer only -> occ 0; accept only -> skid loaded, occ 2; neither -> hold.
REQ-024 occ=2: transfer -> skid moves to main, occ 1; no accept possible; no transfer -> hold both.
REQ-025 Order preserved: entries leave in acceptance order; zero-bubble throughput of 1 entry/cycle when out_ready_i held high.
REQ-026 Latency: entry accepted at edge N is presented at N+1 earliest (occ was 0 or 1 with concurrent transfer).
REQ-027 flush_i high: next cycle occ=0, both registers cleared (pc 0, inst NOP_INST); overrides accept and transfer in the same cycle.
REQ-028 Flush drop count: drop_cnt_o += occ at flush edge (incoming entry not counted); saturates at 2^CNT_W-1, never wraps.
REQ-029 Held data SHALL not change while not transferred (stall holds exactly, no re-load).

Reset
REQ-030 rst_i high at an edge: occ=0, main/skid pc 0 and inst NOP_INST, drop_cnt_o=0; takes priority over flush_i, accept, transfer.
REQ-031 While rst_i high: in_ready_o=0, out_valid_o=0; mid-operation reset discards contents without incrementing drop_cnt_o.

Verification
REQ-032 Reset, then in_valid_i=1 pc 0x100/0x104/0x108 streaming, out_ready_i=1 -> out_pc_o 0x100,0x104,0x108 on consecutive cycles, occ_o stays 1.
REQ-033 Stall: occ 1 (pc 0x200), out_ready_i=0, push 0x204 -> occ_o=2, in_ready_o=0; 0x208 held off; release -> 0x200,0x204,0x208 in order.
REQ-034 Flush with occ 2 and in_valid_i=1 -> next cycle occ_o=0, out_valid_o=0, out_inst_o=NOP_INST, drop_cnt_o +2, incoming entry absent.
REQ-035 CNT_W=2, four flushes at occ 2 -> drop_cnt_o 2,3,3,3 (saturation).
REQ-036 rst_i asserted with occ 2 and flush_i=1 -> occ_o=0, drop_cnt_o=0, in_ready_o=0 during reset, 1 the cycle after release.
